// File: rtl/seq_mul_add_pkg.sv
// Shared state encodings and representation names for the sequential
// multiply-add block and the lpm_divide wrapper users.
package seq_mul_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam string REP_UNSIGNED = "UNSIGNED";
  localparam string REP_SIGNED   = "SIGNED";

endpackage

// File: rtl/seq_mul_add_dp.sv
// Datapath for seq_mul_add: operand magnitudes, shift-add accumulator,
// sign fix-up plus addend, and the result register.
module seq_mul_add_dp
  import seq_mul_add_pkg::*;
#(
  parameter int    lpm_widtha         = 32,
  parameter int    lpm_widthb         = 32,
  parameter string lpm_representation = REP_UNSIGNED,
  parameter int    CW                 = 6
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             load,
  input  logic                             step,
  input  logic                             fix,
  input  logic [lpm_widtha-1:0]            a,
  input  logic [lpm_widthb-1:0]            b,
  input  logic [lpm_widthb-1:0]            c,
  input  logic [CW-1:0]                    cnt,
  output logic [lpm_widtha+lpm_widthb-1:0] result
);
  localparam int W         = lpm_widtha + lpm_widthb;
  localparam bit IS_SIGNED = (lpm_representation == REP_SIGNED);

  logic [lpm_widtha-1:0] ma, a_mag;
  logic [lpm_widthb-1:0] mb, b_mag, mb_sh;
  logic [W-1:0]          acc, c_ext, c_ext_d, addend, fixed;
  logic                  sign, sign_d;

  // Magnitudes fit in the operand width: |-2^(w-1)| = 2^(w-1) read unsigned.
  always_comb begin
    a_mag   = a;
    b_mag   = b;
    sign_d  = 1'b0;
    c_ext_d = {{lpm_widtha{1'b0}}, c};
    if (IS_SIGNED) begin
      if (a[lpm_widtha-1]) a_mag = -a;
      if (b[lpm_widthb-1]) b_mag = -b;
      sign_d  = a[lpm_widtha-1] ^ b[lpm_widthb-1];
      c_ext_d = {{lpm_widtha{c[lpm_widthb-1]}}, c};
    end
  end

  always_comb begin
    mb_sh  = mb >> cnt;
    addend = W'(ma) << cnt;
    fixed  = (sign ? -acc : acc) + c_ext;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ma     <= '0;
      mb     <= '0;
      c_ext  <= '0;
      sign   <= 1'b0;
      acc    <= '0;
      result <= '0;
    end else if (load) begin
      ma    <= a_mag;
      mb    <= b_mag;
      c_ext <= c_ext_d;
      sign  <= sign_d;
      acc   <= '0;
    end else if (step) begin
      if (mb_sh[0]) acc <= acc + addend;
    end else if (fix) begin
      acc    <= fixed;
      result <= fixed;
    end
  end

endmodule

// File: rtl/seq_mul_add.sv
// Radix-2 shift-add a*b+c with valid/ready on both sides; FSM, iteration
// counter and handshake live here, arithmetic in seq_mul_add_dp.
module seq_mul_add
  import seq_mul_add_pkg::*;
#(
  parameter int    lpm_widtha         = 32,
  parameter int    lpm_widthb         = 32,
  parameter string lpm_representation = REP_UNSIGNED
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clken,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [lpm_widtha-1:0]            a,
  input  logic [lpm_widthb-1:0]            b,
  input  logic [lpm_widthb-1:0]            c,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [lpm_widtha+lpm_widthb-1:0] result,
  output logic                             busy
);
  localparam int CW = $clog2(lpm_widthb + 1);

  state_e        state;
  logic [CW-1:0] cnt;
  logic          accept, run_last, step, fix;

  assign in_ready = clken & ~reset & (state == ST_IDLE);
  assign accept   = in_valid & in_ready;
  assign busy     = (state != ST_IDLE);
  assign run_last = (cnt == CW'(lpm_widthb));
  assign step     = clken & (state == ST_RUN) & ~run_last;
  assign fix      = clken & (state == ST_FIX);

  // The RUN exit check costs one extra edge, giving widthb+2 edges to out_valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (clken) begin
      case (state)
        ST_IDLE: if (accept) begin
          state <= ST_RUN;
          cnt   <= '0;
        end
        ST_RUN: begin
          if (run_last) state <= ST_FIX;
          else          cnt   <= cnt + 1'b1;
        end
        ST_FIX: begin
          state     <= ST_DONE;
          out_valid <= 1'b1;
        end
        ST_DONE: if (out_ready) begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  seq_mul_add_dp #(
    .lpm_widtha(lpm_widtha),
    .lpm_widthb(lpm_widthb),
    .lpm_representation(lpm_representation),
    .CW(CW)
  ) u_dp (
    .clock(clock),
    .reset(reset),
    .load(accept),
    .step(step),
    .fix(fix),
    .a(a),
    .b(b),
    .c(c),
    .cnt(cnt),
    .result(result)
  );

endmodule

// File: tb/tb_seq_mul_add.sv
// Directed bench for seq_mul_add, 8x8: an unsigned and a signed instance
// share stimulus; expected results are hand-computed a*b+c values.
module tb_seq_mul_add;
  logic        clk = 1'b0;
  logic        reset = 1'b1, clken = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  a = '0, b = '0, c = '0;
  logic        ir_u, ir_s, ov_u, ov_s, busy_u, busy_s;
  logic [15:0] res_u, res_s;
  int          n_cmp = 0, n_bad = 0;
  int          lat;

  always #5 clk = ~clk;

  seq_mul_add #(.lpm_widtha(8), .lpm_widthb(8), .lpm_representation("UNSIGNED")) u_dut (
    .clock(clk), .reset(reset), .clken(clken), .in_valid(in_valid), .in_ready(ir_u),
    .a(a), .b(b), .c(c), .out_valid(ov_u), .out_ready(out_ready), .result(res_u), .busy(busy_u));

  seq_mul_add #(.lpm_widtha(8), .lpm_widthb(8), .lpm_representation("SIGNED")) s_dut (
    .clock(clk), .reset(reset), .clken(clken), .in_valid(in_valid), .in_ready(ir_s),
    .a(a), .b(b), .c(c), .out_valid(ov_s), .out_ready(out_ready), .result(res_s), .busy(busy_s));

  // Offers one op, scrambles inputs after the accept edge, and returns the
  // number of edges after accept until out_valid (-1 on timeout). A nonzero
  // stall drops clken for 3 edges starting after edge 'stall'.
  task automatic run_op(input logic [7:0] ia, ib, ic, input int stall, output int l);
    @(negedge clk);
    a = ia; b = ib; c = ic; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'h5A; b = 8'hC3; c = 8'h3C;
    l = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ov_u && ov_s) begin l = i; break; end
      if (stall != 0 && i == stall)     clken = 1'b0;
      if (stall != 0 && i == stall + 3) clken = 1'b1;
    end
    clken = 1'b1;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ir_u !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", ir_u); end
    n_cmp++; if ({ov_u, ov_s, busy_u, busy_s} !== 4'b0) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {ov_u, ov_s, busy_u, busy_s}); end
    n_cmp++; if (res_u !== 16'h0 || res_s !== 16'h0) begin n_bad++; $display("FAIL reset_result got %h/%h want 0000/0000", res_u, res_s); end
    reset = 1'b0;
    #1;
    n_cmp++; if (ir_u !== 1'b1 || ir_s !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got %b%b want 11", ir_u, ir_s); end
  endtask

  task automatic test_unsigned();
    run_op(8'd200, 8'd250, 8'd17, 0, lat);
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL unsigned_latency got %0d want 10", lat); end
    n_cmp++; if (res_u !== 16'hC361) begin n_bad++; $display("FAIL unsigned_res got %h want c361", res_u); end
    n_cmp++; if (res_s !== 16'h0161) begin n_bad++; $display("FAIL signed_view_res got %h want 0161", res_s); end
    n_cmp++; if (ir_u !== 1'b0 || busy_u !== 1'b1) begin n_bad++; $display("FAIL done_flags got ir=%b busy=%b want 0/1", ir_u, busy_u); end
    handoff();
    n_cmp++; if (ov_u !== 1'b0 || busy_u !== 1'b0 || ir_u !== 1'b1) begin n_bad++; $display("FAIL after_handoff got ov=%b busy=%b ir=%b want 0/0/1", ov_u, busy_u, ir_u); end
    n_cmp++; if (res_u !== 16'hC361) begin n_bad++; $display("FAIL result_held got %h want c361", res_u); end
  endtask

  task automatic test_signed();
    run_op(8'h80, 8'h80, 8'h7F, 0, lat);
    n_cmp++; if (res_s !== 16'd16511 || res_u !== 16'd16511) begin n_bad++; $display("FAIL most_negative got %h/%h want 407f/407f", res_s, res_u); end
    handoff();
    run_op(8'hF9, 8'h03, 8'hFE, 0, lat);
    n_cmp++; if (res_s !== 16'hFFE9) begin n_bad++; $display("FAIL signed_neg got %h want ffe9", res_s); end
    n_cmp++; if (res_u !== 16'h03E9) begin n_bad++; $display("FAIL unsigned_view got %h want 03e9", res_u); end
    handoff();
    run_op(8'h00, 8'h55, 8'h90, 0, lat);
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL zero_latency got %0d want 10", lat); end
    n_cmp++; if (res_u !== 16'h0090 || res_s !== 16'hFF90) begin n_bad++; $display("FAIL zero_a got %h/%h want 0090/ff90", res_u, res_s); end
    handoff();
  endtask

  task automatic test_backpressure();
    run_op(8'd10, 8'd10, 8'd5, 0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'd3; b = 8'd4; c = 8'd5;
      n_cmp++; if (ov_u !== 1'b1 || res_u !== 16'h0069 || ir_u !== 1'b0) begin n_bad++; $display("FAIL backpressure_hold got ov=%b res=%h ir=%b want 1/0069/0", ov_u, res_u, ir_u); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    n_cmp++; if (ov_u !== 1'b0 || busy_u !== 1'b0) begin n_bad++; $display("FAIL release_idle got ov=%b busy=%b want 0/0", ov_u, busy_u); end
    run_op(8'd3, 8'd4, 8'd5, 0, lat);
    n_cmp++; if (lat !== 10 || res_u !== 16'd17) begin n_bad++; $display("FAIL next_op got lat=%0d res=%h want 10/0011", lat, res_u); end
    handoff();
  endtask

  task automatic test_clken();
    run_op(8'd12, 8'd13, 8'd14, 3, lat);
    n_cmp++; if (lat !== 13) begin n_bad++; $display("FAIL clken_latency got %0d want 13", lat); end
    n_cmp++; if (res_u !== 16'h00AA || res_s !== 16'h00AA) begin n_bad++; $display("FAIL clken_res got %h/%h want 00aa/00aa", res_u, res_s); end
    clken = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ov_u !== 1'b1 || ir_u !== 1'b0) begin n_bad++; $display("FAIL clken_frozen_done got ov=%b ir=%b want 1/0", ov_u, ir_u); end
    clken = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (ov_u !== 1'b0) begin n_bad++; $display("FAIL clken_handoff got ov=%b want 0", ov_u); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a = 8'd9; b = 8'd9; c = 8'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ov_u !== 1'b0 || busy_u !== 1'b0 || res_u !== 16'h0) begin n_bad++; $display("FAIL reset_mid got ov=%b busy=%b res=%h want 0/0/0000", ov_u, busy_u, res_u); end
    reset = 1'b0;
    run_op(8'hFF, 8'hFF, 8'hFF, 0, lat);
    n_cmp++; if (res_u !== 16'hFF00 || res_s !== 16'h0000) begin n_bad++; $display("FAIL after_reset_op got %h/%h want ff00/0000", res_u, res_s); end
    handoff();
  endtask

  task automatic test_back_to_back();
    run_op(8'd7, 8'd6, 8'd1, 0, lat);
    handoff();
    run_op(8'd255, 8'd1, 8'd0, 0, lat);
    n_cmp++; if (lat !== 10 || res_u !== 16'h00FF || res_s !== 16'hFFFF) begin n_bad++; $display("FAIL back_to_back got lat=%0d res=%h/%h want 10/00ff/ffff", lat, res_u, res_s); end
    handoff();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_clken();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
